// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush scheduler for the 5-stage pipeline. It handles
// load-use interlock, branch/jump redirect with multi-bubble front-end
// flush, and the MEM-stage data-memory wait with an optional timeout.
//
// Parameters:
//   REDIRECT_BUBBLES  front-end flush cycles after a redirect (1..3)
//   MEM_TIMEOUT       max HOLD cycles before forced release (0 = never)
//
// Ports:
//   clk, reset (async, active-low)
//   rs1_IF, rs2_IF, uses_rs1_IF, uses_rs2_IF   IF-stage source operands
//   rd_ID, dm_rd_ctrl_ID                       IDC-held destination / load ctrl
//   branch_taken_EX                            taken branch/jump resolved in EX
//   dm_req_MEM, dm_ready_MEM                   data-memory handshake
//   stall_IF, stall_IDC, stall_EX              register holds
//   flush_IF, flush_IDC                        bubble inserts
//   mem_timeout                                pulse on forced MEM_WAIT release
//   hz_state                                   0 RUN, 1 MEM_WAIT, 2 REDIRECT
//
// Optional feature macro HAZARD_PERF_EN adds perf_stall_cycles,
// perf_flush_cycles and perf_lu_events (32-bit, wrapping).

module pipeline_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_IF,
    input  logic [4:0]  rs2_IF,
    input  logic        uses_rs1_IF,
    input  logic        uses_rs2_IF,
    input  logic [4:0]  rd_ID,
    input  logic [2:0]  dm_rd_ctrl_ID,
    input  logic        branch_taken_EX,
    input  logic        dm_req_MEM,
    input  logic        dm_ready_MEM,
    output logic        stall_IF,
    output logic        stall_IDC,
    output logic        stall_EX,
    output logic        flush_IF,
    output logic        flush_IDC,
    output logic        mem_timeout,
    output logic [1:0]  hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cycles,
    output logic [31:0] perf_lu_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam int           TW          = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]   CNT_LOAD    = 2'(REDIRECT_BUBBLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(MEM_TIMEOUT - 1);
    localparam bit           TMO_EN      = (MEM_TIMEOUT != 0);
    localparam bit           REDIR_MULTI = (REDIRECT_BUBBLES > 1);

    state_t          state, state_n;
    logic [1:0]      cnt, cnt_n;
    logic [TW-1:0]   timer, timer_n;
    logic            pend, pend_n;

    logic            lu, miss, tmo_hit;
    logic            hold_act, redir_act, lu_act, tmo_act;

    assign lu = (dm_rd_ctrl_ID != 3'd0) && (rd_ID != 5'd0) &&
                ((uses_rs1_IF && (rs1_IF == rd_ID)) ||
                 (uses_rs2_IF && (rs2_IF == rd_ID)));
    assign miss    = dm_req_MEM && !dm_ready_MEM;
    assign tmo_hit = TMO_EN && (timer == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
            timer <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            timer <= timer_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        timer_n   = timer;
        pend_n    = pend;
        hold_act  = 1'b0;
        redir_act = 1'b0;
        lu_act    = 1'b0;
        tmo_act   = 1'b0;
        case (state)
            RUN: begin
                if (miss) begin
                    hold_act = 1'b1;
                    timer_n  = '0;
                    state_n  = MEM_WAIT;
                end else if (branch_taken_EX) begin
                    redir_act = 1'b1;
                    cnt_n     = CNT_LOAD;
                    state_n   = REDIR_MULTI ? REDIRECT : RUN;
                end else if (lu) begin
                    lu_act = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (miss && !tmo_hit) begin
                    hold_act = 1'b1;
                    timer_n  = timer + TW'(1);
                end else begin
                    // Release cycle (ready, request dropped, or timeout):
                    // decision rule without the miss term.
                    tmo_act = tmo_hit;
                    timer_n = '0;
                    pend_n  = 1'b0;
                    if (branch_taken_EX) begin
                        redir_act = 1'b1;
                        cnt_n     = CNT_LOAD;
                        state_n   = REDIR_MULTI ? REDIRECT : RUN;
                    end else begin
                        lu_act  = lu;
                        // A redirect interrupted by the wait resumes with
                        // the bubble count it had left.
                        state_n = pend ? REDIRECT : RUN;
                    end
                end
            end
            REDIRECT: begin
                if (miss) begin
                    hold_act = 1'b1;
                    pend_n   = 1'b1;
                    timer_n  = '0;
                    state_n  = MEM_WAIT;
                end else if (branch_taken_EX) begin
                    redir_act = 1'b1;
                    cnt_n     = CNT_LOAD;
                    state_n   = REDIR_MULTI ? REDIRECT : RUN;
                end else begin
                    // The counter holds the flushes still owed; leave once
                    // it reaches zero.
                    redir_act = 1'b1;
                    cnt_n     = cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        cnt_n   = '0;
                        state_n = RUN;
                    end
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted.
    assign stall_IF    = reset && (hold_act || lu_act);
    assign stall_IDC   = reset && hold_act;
    assign stall_EX    = reset && hold_act;
    assign flush_IF    = reset && redir_act;
    assign flush_IDC   = reset && (redir_act || lu_act);
    assign mem_timeout = reset && tmo_act;
    assign hz_state    = state;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
            perf_lu_events    <= '0;
        end else begin
            if (stall_IF)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_IF)  perf_flush_cycles <= perf_flush_cycles + 32'd1;
            if (lu_act)    perf_lu_events    <= perf_lu_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REDIRECT_BUBBLES=2, MEM_TIMEOUT=4).
// Observed vector: {stall_IF, stall_IDC, stall_EX, flush_IF, flush_IDC,
//                   mem_timeout, hz_state[1:0]}.
// Control vector:  {dm_req_MEM, dm_ready_MEM, branch_taken_EX, load_use}.

module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_IF, rs2_IF, rd_ID;
    logic       uses_rs1_IF, uses_rs2_IF;
    logic [2:0] dm_rd_ctrl_ID;
    logic       branch_taken_EX, dm_req_MEM, dm_ready_MEM;
    logic       stall_IF, stall_IDC, stall_EX, flush_IF, flush_IDC, mem_timeout;
    logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cycles, perf_lu_events;
`endif

    int n_checks;
    int n_pass;

    logic [7:0] obs;
    assign obs = {stall_IF, stall_IDC, stall_EX, flush_IF, flush_IDC, mem_timeout, hz_state};

    pipeline_hazard_ctrl #(
        .REDIRECT_BUBBLES(2),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rs1_IF(rs1_IF),
        .rs2_IF(rs2_IF),
        .uses_rs1_IF(uses_rs1_IF),
        .uses_rs2_IF(uses_rs2_IF),
        .rd_ID(rd_ID),
        .dm_rd_ctrl_ID(dm_rd_ctrl_ID),
        .branch_taken_EX(branch_taken_EX),
        .dm_req_MEM(dm_req_MEM),
        .dm_ready_MEM(dm_ready_MEM),
        .stall_IF(stall_IF),
        .stall_IDC(stall_IDC),
        .stall_EX(stall_EX),
        .flush_IF(flush_IF),
        .flush_IDC(flush_IDC),
        .mem_timeout(mem_timeout),
        .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_cycles(perf_flush_cycles),
        .perf_lu_events(perf_lu_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        dm_req_MEM      = v[3];
        dm_ready_MEM    = v[2];
        branch_taken_EX = v[1];
        rs1_IF          = 5'd9;
        rs2_IF          = 5'd0;
        uses_rs1_IF     = 1'b1;
        uses_rs2_IF     = 1'b0;
        rd_ID           = 5'd9;
        dm_rd_ctrl_ID   = v[0] ? 3'd2 : 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'b0000);
        #2;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_async got %h want %h", obs, 8'h00);
        else n_pass++;
        tick();
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_held got %h want %h", obs, 8'h00);
        else n_pass++;
        reset = 1'b1;
        #2;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_release got %h want %h", obs, 8'h00);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        logic [19:0] lv [6];
        logic [7:0]  ex [6];
        lv = '{ {3'd1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0},
                {3'd3, 5'd7,  5'd1,  5'd7,  1'b1, 1'b1},
                {3'd0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0},
                {3'd1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1},
                {3'd1, 5'd5,  5'd5,  5'd4,  1'b0, 1'b1},
                {3'd4, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0} };
        ex = '{8'h88, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            {dm_rd_ctrl_ID, rd_ID, rs1_IF, rs2_IF, uses_rs1_IF, uses_rs2_IF} = lv[i];
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL load_use[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
        drive(4'b0000);
        #2;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL load_use_after got %h want %h", obs, 8'h00);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] st [3];
        logic [7:0] ex [3];
        st = '{4'b0010, 4'b0000, 4'b0000};
        ex = '{8'h18, 8'h1A, 8'h00};
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL branch[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mem_wait();
        logic [3:0] st [5];
        logic [7:0] ex [5];
        st = '{4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b0000};
        ex = '{8'hE0, 8'hE1, 8'hE1, 8'h01, 8'h00};
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL mem_wait[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_timeout();
        logic [3:0] st [6];
        logic [7:0] ex [6];
        st = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        ex = '{8'hE0, 8'hE1, 8'hE1, 8'hE1, 8'h05, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL timeout[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_priority();
        logic [3:0] st [11];
        logic [7:0] ex [11];
        st = '{4'b1011, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b0011,
               4'b0000, 4'b0000, 4'b1000, 4'b1001, 4'b1101};
        ex = '{8'hE0, 8'hE1, 8'h19, 8'h1A, 8'h00, 8'h18,
               8'h1A, 8'h00, 8'hE0, 8'hE1, 8'h89};
        for (int i = 0; i < 11; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL priority[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
        drive(4'b0000);
        #2;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL priority_end got %h want %h", obs, 8'h00);
        else n_pass++;
        tick();
    endtask

    task automatic test_pending();
        logic [3:0] st [6];
        logic [7:0] ex [6];
        st = '{4'b0010, 4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b0000};
        ex = '{8'h18, 8'hE2, 8'hE1, 8'h01, 8'h1A, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL pending[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] st [4];
        logic [7:0] ex [4];
        st = '{4'b0010, 4'b0010, 4'b0001, 4'b0000};
        ex = '{8'h18, 8'h1A, 8'h1A, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            #2;
            n_checks++;
            if (obs !== ex[i]) $display("FAIL back_to_back[%0d] got %h want %h", i, obs, ex[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b0010);
        #2;
        n_checks++;
        if (obs !== 8'h18) $display("FAIL rstmid_branch got %h want %h", obs, 8'h18);
        else n_pass++;
        tick();
        drive(4'b0000);
        #2;
        n_checks++;
        if (obs !== 8'h1A) $display("FAIL rstmid_redirect got %h want %h", obs, 8'h1A);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL rstmid_async got %h want %h", obs, 8'h00);
        else n_pass++;
        tick();
        reset = 1'b1;
        #2;
        n_checks++;
        if (obs !== 8'h00) $display("FAIL rstmid_after got %h want %h", obs, 8'h00);
        else n_pass++;
`ifdef HAZARD_PERF_EN
        n_checks++;
        if ({perf_stall_cycles, perf_flush_cycles, perf_lu_events} !== 96'd0)
            $display("FAIL rstmid_perf got %0d/%0d/%0d want 0/0/0",
                     perf_stall_cycles, perf_flush_cycles, perf_lu_events);
        else n_pass++;
`endif
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        logic [3:0] st [6];
        st = '{4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b1100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            tick();
        end
        n_checks++;
        if (perf_stall_cycles !== 32'd2) $display("FAIL perf_stall got %0d want 2", perf_stall_cycles);
        else n_pass++;
        n_checks++;
        if (perf_flush_cycles !== 32'd2) $display("FAIL perf_flush got %0d want 2", perf_flush_cycles);
        else n_pass++;
        n_checks++;
        if (perf_lu_events !== 32'd1) $display("FAIL perf_lu got %0d want 1", perf_lu_events);
        else n_pass++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_pending();
        test_back_to_back();
        test_reset_mid();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It watches the instruction in IF, the decoded instruction held in the IDC register, the branch resolution from EX and the MEM-stage data-memory handshake. From these it drives the stall and flush inputs of the IF, IDC and EX/MEM pipeline registers. It owns the only multi-cycle pipeline sequencing: memory-wait hold with timeout, and multi-bubble redirect after a taken branch or jump.

## Interface
Parameters:
- REDIRECT_BUBBLES, 2, cycles the front end (IF and IDC) is flushed after a redirect; legal range 1–3.
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before forced release; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- rs1_IF, rs2_IF  in  5 each  source register fields of the instruction in IF
- uses_rs1_IF, uses_rs2_IF  in  1 each  the IF instruction actually reads rs1/rs2
- rd_ID  in  5  destination register held in the IDC register
- dm_rd_ctrl_ID  in  3  load control held in the IDC register; nonzero means load
- branch_taken_EX  in  1  EX resolved a taken branch or jump this cycle
- dm_req_MEM  in  1  MEM stage issuing a data-memory access
- dm_ready_MEM  in  1  data memory completes the access this cycle
- stall_IF  out  1  hold the PC/IF register
- stall_IDC  out  1  hold the IDC register
- stall_EX  out  1  hold the EX and MEM registers
- flush_IF  out  1  bubble into the IF register
- flush_IDC  out  1  bubble into the IDC register; overrides stall in IDC
- mem_timeout  out  1  one-cycle pulse on forced MEM_WAIT release
- hz_state  out  2  current FSM state: 0 RUN, 1 MEM_WAIT, 2 REDIRECT

## Operation
- Definitions:
  - lu = dm_rd_ctrl_ID≠0 && rd_ID≠0 && ((uses_rs1_IF && rs1_IF==rd_ID) || (uses_rs2_IF && rs2_IF==rd_ID)).
  - miss = dm_req_MEM && !dm_ready_MEM.
- Outputs are combinational from state and inputs. State, bubble counter, timer and the pending flag are registered.
- Actions:
  - HOLD: stall_IF, stall_IDC and stall_EX are 1; both flushes are 0.
  - REDIR: flush_IF and flush_IDC are 1.
  - LU: stall_IF and flush_IDC are 1. The load advances to EX and a bubble enters IDC.
- Decision rule D, highest priority first:
  - miss → HOLD.
  - branch_taken_EX → REDIR, load the bubble counter with REDIRECT_BUBBLES−1.
  - lu → LU.
  - Otherwise all outputs are 0.
- RUN:
  - Apply D.
  - miss → MEM_WAIT and clear the timer.
  - REDIR with REDIRECT_BUBBLES>1 → REDIRECT.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - While miss: HOLD, and the timer increments.
  - On dm_ready_MEM (release cycle): apply D without the miss term, then go to the state D selects.
  - If no redirect occurs and pending=1, go to REDIRECT with the retained counter.
  - Timeout, when timer==MEM_TIMEOUT−1 and MEM_TIMEOUT≠0: pulse mem_timeout, handle the cycle as a release cycle, and the timer clears.
- REDIRECT:
  - REDIR each cycle; the counter decrements; return to RUN after the cycle in which the counter is 0.
  - miss wins: HOLD, set pending=1, freeze the counter, go to MEM_WAIT.
  - branch_taken_EX reloads the counter.
  - lu is ignored in REDIRECT.
- Timer width is $clog2(MEM_TIMEOUT+1) with a minimum of 1. The counter is 2 bits.

## Timing
- Reset values: all outputs 0, hz_state=0 (RUN), counter=0, timer=0, pending=0.
- Reset is asynchronous and takes effect mid-operation from any state; the first active clock after reset is in RUN.
- Zero-cycle reaction: stall/flush outputs are valid in the same cycle as the triggering input.
- Load-use inserts exactly 1 bubble.
- A redirect flushes the front end for REDIRECT_BUBBLES consecutive cycles, excluding HOLD cycles.
- A miss with ready after N cycles gives N HOLD cycles. The release cycle has stall_EX=0.
- The timeout forces release after exactly MEM_TIMEOUT HOLD cycles.
- Simultaneous events:
  - miss beats branch, and branch beats load-use.
  - branch_taken_EX and dm_ready_MEM together in MEM_WAIT redirect on that same cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] (cycles with stall_IF=1), perf_flush_cycles[31:0] (cycles with flush_IF=1) and perf_lu_events[31:0] (LU actions).
  - All three wrap modulo 2^32 and reset to 0.
- HAZARD_PERF_EN undefined: these ports and their counters do not exist, and all other behaviour is identical.

## Test plan
- Load-use: rd_ID=5, dm_rd_ctrl_ID=3'b001, rs1_IF=5, uses_rs1_IF=1 → one cycle with stall_IF=1 and flush_IDC=1, stall_EX=0, hz_state=0.
- Branch: branch_taken_EX pulse with REDIRECT_BUBBLES=2 → flush_IF and flush_IDC are 1 for 2 cycles, hz_state goes 0→2→0.
- Memory wait: dm_req_MEM=1 with dm_ready_MEM=0 for 3 cycles, then 1 → stall_IF, stall_IDC and stall_EX are 1 for exactly 3 cycles, all outputs are 0 on the ready cycle, and the FSM returns to RUN.
- Timeout: MEM_TIMEOUT=4, dm_ready_MEM held at 0 → 4 HOLD cycles, then mem_timeout=1 for one cycle and the stalls drop.
- Priority: miss together with branch_taken_EX and lu in RUN → HOLD only. Ready arrives with branch_taken_EX=1 → REDIR on that cycle.
- Reset mid-REDIRECT, with reset low for 1 cycle → all outputs 0 immediately and hz_state=0; with HAZARD_PERF_EN defined, the perf counters also read 0.
